fm_gate_sequencer: RTL

Measurement sequencer for the digital frequency meter. It drives the enable, clear and latch strobes of the 6-digit BCD counter and the 24-bit result latch. Gate length is programmable over four decade ranges, and an optional auto-ranging loop adjusts the range from overflow and leading-digit feedback. It replaces the fixed 16-cycle timing controller and sits between the reference clock and the counter/latch pair.

---
 rtl/fm_gate_sequencer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/fm_gate_sequencer.sv
// Measurement sequencer for the digital frequency meter.
// Drives the clear / enable / latch strobes of the 6-digit BCD counter and the
// result latch. The gate length is BASE_GATE * 10^range. An optional auto-range
// loop steps the range down on overflow and up when the leading digits are zero.
// Optional feature macro: FMSEQ_HOLD_EN adds a 'hold' input that suppresses the
// latch strobe (and the valid pulse) so the displayed value freezes.
module fm_gate_sequencer #(
  parameter int unsigned BASE_GATE  = 8,
  parameter int unsigned CLR_CYC    = 2,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       auto_en,
  input  logic [1:0] range_sel,
  input  logic       ovf,
  input  logic       msd_zero,
`ifdef FMSEQ_HOLD_EN
  input  logic       hold,
`endif
  output logic       enb,
  output logic       clr,
  output logic       lock,
  output logic [1:0] range_cur,
  output logic       valid,
  output logic       ovr,
  output logic       busy
);

  // Terminal counts (length - 1) for each phase.
  localparam logic [CNT_W-1:0] ClrLast    = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] GateLast0  = CNT_W'(BASE_GATE - 1);
  localparam logic [CNT_W-1:0] GateLast1  = CNT_W'(BASE_GATE * 10 - 1);
  localparam logic [CNT_W-1:0] GateLast2  = CNT_W'(BASE_GATE * 100 - 1);
  localparam logic [CNT_W-1:0] GateLast3  = CNT_W'(BASE_GATE * 1000 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGate,
    StSettle,
    StLatch,
    StEval
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       range_q, range_d;
  logic             ovf_seen_q, ovf_seen_d;
  logic             skip_q, skip_d;
  logic             ovr_q, ovr_d;
  logic             enb_q, enb_d;
  logic             clr_q, clr_d;
  logic             lock_q, lock_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic             ovf_s1_q, ovf_s2_q;
  logic             msd_s1_q, msd_s2_q;
  logic             hold_sync;
  logic [CNT_W-1:0] gate_last;

  // Two-flop synchronisers for the f_in-domain status bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_s1_q <= 1'b0;
      ovf_s2_q <= 1'b0;
      msd_s1_q <= 1'b0;
      msd_s2_q <= 1'b0;
    end else begin
      ovf_s1_q <= ovf;
      ovf_s2_q <= ovf_s1_q;
      msd_s1_q <= msd_zero;
      msd_s2_q <= msd_s1_q;
    end
  end

`ifdef FMSEQ_HOLD_EN
  logic hold_s1_q, hold_s2_q;

  // Synchroniser for the display-hold request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_s1_q <= 1'b0;
      hold_s2_q <= 1'b0;
    end else begin
      hold_s1_q <= hold;
      hold_s2_q <= hold_s1_q;
    end
  end

  assign hold_sync = hold_s2_q;
`else
  assign hold_sync = 1'b0;
`endif

  // Gate terminal count for the range of the measurement in progress.
  always_comb begin
    gate_last = GateLast0;
    unique case (range_q)
      2'd0: gate_last = GateLast0;
      2'd1: gate_last = GateLast1;
      2'd2: gate_last = GateLast2;
      2'd3: gate_last = GateLast3;
    endcase
  end

  // Next-state, phase counter, range/overflow bookkeeping and strobe decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    range_d    = range_q;
    ovf_seen_d = ovf_seen_q;
    skip_d     = skip_q;
    ovr_d      = ovr_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (run) begin
          state_d = StClear;
          // Manual range is only picked up when leaving IDLE.
          if (!auto_en) begin
            range_d = range_sel;
          end
        end
      end

      StClear: begin
        ovf_seen_d = 1'b0;
        if (cnt_q == ClrLast) begin
          state_d = StGate;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StGate: begin
        if (ovf_s2_q) begin
          ovf_seen_d = 1'b1;
        end
        if (cnt_q == gate_last) begin
          state_d = StSettle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d = StLatch;
          cnt_d   = '0;
          // Hold is decided once, on the way into LATCH, and kept through EVAL.
          skip_d  = hold_sync;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StLatch: begin
        state_d = StEval;
        // ovr changes together with the valid pulse.
        if (!skip_q) begin
          ovr_d = ovf_seen_q;
        end
      end

      StEval: begin
        if (auto_en && !skip_q) begin
          // Overflow takes priority over the leading-zero step-up.
          if (ovf_seen_q && (range_q != 2'd0)) begin
            range_d = range_q - 2'd1;
          end else if (msd_s2_q && (range_q != 2'd3)) begin
            range_d = range_q + 2'd1;
          end
        end
        state_d = run ? StClear : StIdle;
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Strobes are registered copies of the next state, so they are glitch-free
    // and mutually exclusive by construction.
    enb_d   = (state_d == StGate);
    clr_d   = (state_d == StClear);
    lock_d  = (state_d == StLatch) && !skip_d;
    valid_d = (state_d == StEval) && !skip_d;
    busy_d  = (state_d != StIdle);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      range_q    <= 2'd0;
      ovf_seen_q <= 1'b0;
      skip_q     <= 1'b0;
      ovr_q      <= 1'b0;
      enb_q      <= 1'b0;
      clr_q      <= 1'b0;
      lock_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      range_q    <= range_d;
      ovf_seen_q <= ovf_seen_d;
      skip_q     <= skip_d;
      ovr_q      <= ovr_d;
      enb_q      <= enb_d;
      clr_q      <= clr_d;
      lock_q     <= lock_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign enb       = enb_q;
  assign clr       = clr_q;
  assign lock      = lock_q;
  assign valid     = valid_q;
  assign ovr       = ovr_q;
  assign busy      = busy_q;
  assign range_cur = range_q;

endmodule
